// File: rtl/conv3x3_sched.sv
// Sequencer that walks an IMG_W x IMG_H image, fetches each valid 3x3 window from
// sync-read pixel memory, presents it to an external MAC and writes the results row-major.
module conv3x3_sched #(
    parameter int total_bits = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [9*total_bits-1:0] kernel,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [total_bits-1:0]   rd_data,
    output logic [9*total_bits-1:0] win_pix,
    output logic [9*total_bits-1:0] win_ker,
    input  logic [total_bits-1:0]   mac_y,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [total_bits-1:0]   wr_data,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, CALC, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] img_w    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] out_w    = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] last_col = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] last_row = ADDR_W'(IMG_H - 3);

    state_t            state;
    logic [ADDR_W-1:0] orow;
    logic [ADDR_W-1:0] ocol;
    logic [3:0]        rd_tap;
    logic [3:0]        cap_idx;
    logic              cap_en;

    logic [ADDR_W-1:0] nrow;
    logic [ADDR_W-1:0] ncol;
    logic              last_pos;

    // Pixel address of tap k of the window whose top-left corner is (r, c).
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] r,
                                                   input logic [ADDR_W-1:0] c,
                                                   input logic [3:0]        k);
        logic [ADDR_W-1:0] dr;
        logic [ADDR_W-1:0] dc;
        dr = ADDR_W'(k / 4'd3);
        dc = ADDR_W'(k % 4'd3);
        return (r + dr) * img_w + c + dc;
    endfunction

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        nrow     = orow;
        ncol     = ocol + 1'b1;
        last_pos = (ocol == last_col) && (orow == last_row);
        if (ocol == last_col) begin
            nrow = orow + 1'b1;
            ncol = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the window and kernel
    // registers are cleared by reset too, so a reset mid-frame leaves nothing stale on the MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            orow    <= '0;
            ocol    <= '0;
            rd_tap  <= '0;
            cap_idx <= '0;
            cap_en  <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            win_pix <= '0;
            win_ker <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Read data arrives one cycle after its strobe; remember which slot it belongs to.
            cap_en  <= rd_en;
            cap_idx <= rd_tap;
            if (cap_en) begin
                win_pix[int'(cap_idx)*total_bits +: total_bits] <= rd_data;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        win_ker <= kernel;
                        orow    <= '0;
                        ocol    <= '0;
                        rd_tap  <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= tap_addr('0, '0, 4'd0);
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_tap == 4'd8) begin
                        rd_en <= 1'b0;
                        state <= LAST;
                    end else begin
                        rd_tap  <= rd_tap + 1'b1;
                        rd_addr <= tap_addr(orow, ocol, rd_tap + 1'b1);
                    end
                end
                LAST: begin
                    state <= CALC;
                end
                CALC: begin
                    wr_data <= mac_y;
                    wr_addr <= orow * out_w + ocol;
                    wr_en   <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (last_pos) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        orow    <= nrow;
                        ocol    <= ncol;
                        rd_tap  <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= tap_addr(nrow, ncol, 4'd0);
                        state   <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
